// File: rtl/move_controller.sv
`timescale 1ns/1ps
// move_controller: per-frame movement command generator (walk, jump rise, gravity fall).
// Define MOVE_CTRL_DOUBLE_JUMP_EN to allow one extra jump while airborne.
module move_controller #(
  parameter int unsigned TICK_DIV   = 833333,
  parameter int unsigned GROUND_Y   = 400,
  parameter int unsigned JUMP_V0    = 12,
  parameter int unsigned GRAVITY    = 1,
  parameter int unsigned MAX_FALL   = 8,
  parameter int unsigned WALK_SPEED = 2,
  parameter int unsigned X_MIN      = 0,
  parameter int unsigned X_MAX      = 620
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_jump,
  input  logic [31:0] Coordinate,
  output logic [3:0]  Move_arrow,
  output logic [31:0] Move_speed,
  output logic [1:0]  Jump_state
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [15:0] GND  = 16'(GROUND_Y);
  localparam logic [15:0] JV   = 16'(JUMP_V0);
  localparam logic [15:0] GRAV = 16'(GRAVITY);
  localparam logic [15:0] MAXF = 16'(MAX_FALL);
  localparam logic [15:0] WALK = 16'(WALK_SPEED);
  localparam logic [15:0] XMN  = 16'(X_MIN);
  localparam logic [15:0] XMX  = 16'(X_MAX);

  typedef enum logic [1:0] {GROUND = 2'b00, RISE = 2'b01, FALL = 2'b10} state_e;

  function automatic logic [15:0] min16(input logic [15:0] a, input logic [15:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [15:0] sat_sub(input logic [15:0] a, input logic [15:0] b);
    return (a > b) ? a - b : 16'd0;
  endfunction

  logic [1:0]       left_sync_q, right_sync_q, jump_sync_q;
  logic             jump_prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pending_q, pending_d;
  state_e           state_q, state_d;
  logic [15:0]      vy_q, vy_d;
  logic [3:0]       arrow_q, arrow_d;
  logic [31:0]      speed_q, speed_d;
  logic             tick_c, jump_rise_c, left_c, right_c;
  logic [15:0]      x_c, y_c, gap_c, up_c, dn_c, hspd_c, vnext_c;
`ifdef MOVE_CTRL_DOUBLE_JUMP_EN
  logic             air_q, air_d;
`endif

  assign tick_c      = (cnt_q == CNT_LAST);
  assign jump_rise_c = jump_sync_q[1] & ~jump_prev_q;
  assign left_c      = left_sync_q[1];
  assign right_c     = right_sync_q[1];
  assign x_c         = Coordinate[31:16];
  assign y_c         = Coordinate[15:0];
  assign gap_c       = GND - y_c;

  // Next-state and command computation; a command is produced only in the tick cycle.
  always_comb begin
    cnt_d     = tick_c ? '0 : cnt_q + CNT_W'(1);
    pending_d = tick_c ? jump_rise_c : (pending_q | jump_rise_c);
    state_d   = state_q;
    vy_d      = vy_q;
    arrow_d   = '0;
    speed_d   = '0;
    up_c      = '0;
    dn_c      = '0;
    hspd_c    = '0;
    vnext_c   = '0;
`ifdef MOVE_CTRL_DOUBLE_JUMP_EN
    air_d     = air_q;
`endif
    if (tick_c) begin
`ifdef MOVE_CTRL_DOUBLE_JUMP_EN
      if ((state_q != GROUND) && pending_q && !air_q) begin
        up_c    = JV;
        vy_d    = sat_sub(JV, GRAV);
        state_d = RISE;
        air_d   = 1'b1;
      end else
`endif
      begin
        case (state_q)
          GROUND: begin
            if (pending_q) begin
              up_c    = JV;
              vy_d    = sat_sub(JV, GRAV);
              state_d = RISE;
            end else if (y_c < GND) begin
              dn_c    = min16(GRAV, gap_c);
              vy_d    = GRAV;
              state_d = FALL;
            end
          end
          RISE: begin
            if (vy_q != '0) begin
              up_c = vy_q;
              vy_d = sat_sub(vy_q, GRAV);
            end else begin
              dn_c    = GRAV;
              vy_d    = GRAV;
              state_d = FALL;
            end
          end
          FALL: begin
            if (y_c >= GND) begin
              state_d = GROUND;
              vy_d    = '0;
            end else begin
              vnext_c = min16(vy_q + GRAV, MAXF);
              dn_c    = min16(vnext_c, gap_c);
              vy_d    = vnext_c;
              if (dn_c == gap_c) begin
                state_d = GROUND;
                vy_d    = '0;
              end
            end
          end
          default: begin
            state_d = GROUND;
            vy_d    = '0;
          end
        endcase
      end
`ifdef MOVE_CTRL_DOUBLE_JUMP_EN
      if (state_d == GROUND) air_d = 1'b0;
`endif
      // Walking speed is clamped so X never leaves [X_MIN, X_MAX].
      if (left_c ^ right_c) begin
        if (left_c) hspd_c = min16(WALK, (x_c > XMN) ? x_c - XMN : 16'd0);
        else        hspd_c = min16(WALK, (x_c < XMX) ? XMX - x_c : 16'd0);
      end
      arrow_d = {up_c != '0, dn_c != '0, left_c & (hspd_c != '0), right_c & (hspd_c != '0)};
      speed_d = {(up_c != '0) ? up_c : dn_c, hspd_c};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      left_sync_q  <= '0;
      right_sync_q <= '0;
      jump_sync_q  <= '0;
      jump_prev_q  <= 1'b0;
      cnt_q        <= '0;
      pending_q    <= 1'b0;
      state_q      <= GROUND;
      vy_q         <= '0;
      arrow_q      <= '0;
      speed_q      <= '0;
    end else begin
      left_sync_q  <= {left_sync_q[0], btn_left};
      right_sync_q <= {right_sync_q[0], btn_right};
      jump_sync_q  <= {jump_sync_q[0], btn_jump};
      jump_prev_q  <= jump_sync_q[1];
      cnt_q        <= cnt_d;
      pending_q    <= pending_d;
      state_q      <= state_d;
      vy_q         <= vy_d;
      arrow_q      <= arrow_d;
      speed_q      <= speed_d;
    end
  end

`ifdef MOVE_CTRL_DOUBLE_JUMP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) air_q <= 1'b0;
    else     air_q <= air_d;
  end
`endif

  assign Move_arrow = arrow_q;
  assign Move_speed = speed_q;
  assign Jump_state = state_q;

endmodule

// File: tb/tb_move_controller.sv
`timescale 1ns/1ps
// tb_move_controller: directed + random checks of move_controller against a frame-level model,
// with a coordinate calculator closing the loop.
module tb_move_controller;

  localparam int TD = 4, GY = 400, JV = 5, G = 1, MF = 8, WS = 2, XMN = 0, XMX = 620;
`ifdef MOVE_CTRL_DOUBLE_JUMP_EN
  localparam bit DJ = 1'b1;
`else
  localparam bit DJ = 1'b0;
`endif

  logic        clk, rst, btn_left, btn_right, btn_jump;
  logic [31:0] Coordinate;
  logic [3:0]  Move_arrow;
  logic [31:0] Move_speed;
  logic [1:0]  Jump_state;

  int n_assert, n_fail;
  int m_state, m_vy, m_cyc;
  bit m_pend, m_air;
  bit lh[4], rh[4], jh[4];
  logic [3:0]  exp_arrow, calc_arrow;
  logic [31:0] exp_speed, calc_speed;
  int exp_state, min_y, last_dn, prev_dn;

  move_controller #(
    .TICK_DIV(TD), .GROUND_Y(GY), .JUMP_V0(JV), .GRAVITY(G), .MAX_FALL(MF),
    .WALK_SPEED(WS), .X_MIN(XMN), .X_MAX(XMX)
  ) dut (
    .clk(clk), .rst(rst), .btn_left(btn_left), .btn_right(btn_right), .btn_jump(btn_jump),
    .Coordinate(Coordinate), .Move_arrow(Move_arrow), .Move_speed(Move_speed),
    .Jump_state(Jump_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_vy = 0; m_cyc = 0; m_pend = 1'b0; m_air = 1'b0;
    for (int i = 0; i < 4; i++) begin lh[i] = 1'b0; rh[i] = 1'b0; jh[i] = 1'b0; end
    calc_arrow = '0; calc_speed = '0;
  endtask

  // Predicts the outputs after the coming clock edge from frame-level movement rules.
  task automatic model_edge();
    bit tick, rise, l, r, jp;
    int x, y, up, dn, h, vn;
    for (int i = 3; i > 0; i--) begin lh[i] = lh[i-1]; rh[i] = rh[i-1]; jh[i] = jh[i-1]; end
    lh[0] = btn_left; rh[0] = btn_right; jh[0] = btn_jump;
    l = lh[2]; r = rh[2]; rise = jh[2] && !jh[3];
    tick = ((m_cyc % TD) == TD - 1);
    m_cyc++;
    x = int'(Coordinate[31:16]);
    y = int'(Coordinate[15:0]);
    up = 0; dn = 0; h = 0;
    exp_arrow = '0; exp_speed = '0;
    if (!tick) begin
      m_pend = m_pend | rise;
    end else begin
      jp = m_pend;
      m_pend = rise;
      if (DJ && m_state != 0 && jp && !m_air) begin
        up = JV; m_vy = imax(JV - G, 0); m_state = 1; m_air = 1'b1;
      end else if (m_state == 0) begin
        if (jp) begin up = JV; m_vy = imax(JV - G, 0); m_state = 1; end
        else if (y < GY) begin dn = imin(G, GY - y); m_vy = G; m_state = 2; end
      end else if (m_state == 1) begin
        if (m_vy > 0) begin up = m_vy; m_vy = imax(m_vy - G, 0); end
        else begin dn = G; m_vy = G; m_state = 2; end
      end else begin
        if (y >= GY) begin m_state = 0; m_vy = 0; end
        else begin
          vn = imin(m_vy + G, MF);
          dn = imin(vn, GY - y);
          m_vy = vn;
          if (dn == GY - y) begin m_state = 0; m_vy = 0; end
        end
      end
      if (m_state == 0) m_air = 1'b0;
      if (l && !r) h = imin(WS, imax(x - XMN, 0));
      if (r && !l) h = imin(WS, imax(XMX - x, 0));
      exp_arrow = {up > 0, dn > 0, (l && !r && h > 0), (r && !l && h > 0)};
      exp_speed = {16'(up + dn), 16'(h)};
    end
    exp_state = m_state;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    if (calc_arrow[3]) Coordinate[15:0]  = Coordinate[15:0]  - calc_speed[31:16];
    if (calc_arrow[2]) Coordinate[15:0]  = Coordinate[15:0]  + calc_speed[31:16];
    if (calc_arrow[1]) Coordinate[31:16] = Coordinate[31:16] - calc_speed[15:0];
    if (calc_arrow[0]) Coordinate[31:16] = Coordinate[31:16] + calc_speed[15:0];
    chk("arrow", 32'(Move_arrow), 32'(exp_arrow));
    chk("speed", Move_speed, exp_speed);
    chk("state", 32'(Jump_state), 32'(exp_state));
    calc_arrow = Move_arrow;
    calc_speed = Move_speed;
    if (int'(Coordinate[15:0]) < min_y) min_y = int'(Coordinate[15:0]);
    if (Move_arrow[2]) begin prev_dn = last_dn; last_dn = int'(Move_speed[31:16]); end
  endtask

  task automatic teleport(input logic [31:0] c);
    Coordinate = c;
    calc_arrow = '0;
    calc_speed = '0;
  endtask

  task automatic jump_pulse();
    btn_jump = 1'b1; step(); step(); btn_jump = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_assert = 0; n_fail = 0;
    rst = 1'b1; btn_left = 1'b0; btn_right = 1'b0; btn_jump = 1'b0;
    Coordinate = {16'd320, 16'd100};
    model_reset();
    min_y = 1000; last_dn = 0; prev_dn = 0;

    @(posedge clk); #1;
    chk("rst_arrow", 32'(Move_arrow), 32'd0);
    chk("rst_speed", Move_speed, 32'd0);
    chk("rst_state", 32'(Jump_state), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Fall from Y=100 to the ground.
    repeat (250) step();
    chk("fall_land_y", 32'(Coordinate[15:0]), 32'd400);
    chk("fall_ground", 32'(Jump_state), 32'd0);

    // Single jump from the ground.
    min_y = 1000;
    jump_pulse();
    repeat (80) step();
    chk("jump_peak_y", 32'(min_y), 32'd385);
    chk("jump_land_y", 32'(Coordinate[15:0]), 32'd400);
    chk("jump_ground", 32'(Jump_state), 32'd0);

    // Fall reaching vy=7 at Y=397, final step clamped to 3.
    teleport({16'd320, 16'd369});
    last_dn = 0; prev_dn = 0;
    repeat (60) step();
    chk("clamp_prev_dn", 32'(prev_dn), 32'd7);
    chk("clamp_last_dn", 32'(last_dn), 32'd3);
    chk("clamp_land_y", 32'(Coordinate[15:0]), 32'd400);

    // Walking into the left wall, then both buttons held.
    teleport({16'd1, 16'd400});
    btn_left = 1'b1;
    repeat (16) step();
    chk("wall_x", 32'(Coordinate[31:16]), 32'd0);
    teleport({16'd320, 16'd400});
    btn_right = 1'b1;
    repeat (12) step();
    chk("both_x", 32'(Coordinate[31:16]), 32'd320);
    btn_left = 1'b0; btn_right = 1'b0;
    repeat (4) step();

    // Extra jump presses while airborne.
    min_y = 1000;
    jump_pulse();
    begin
      int n = 0;
      while (n < 40 && !Move_arrow[3]) begin step(); n++; end
    end
    chk("rise_seen", 32'(Move_arrow[3]), 32'd1);
    step();
    jump_pulse();
    repeat (12) step();
    jump_pulse();
    repeat (120) step();
    chk("air_land_y", 32'(Coordinate[15:0]), 32'd400);
    chk("air_ground", 32'(Jump_state), 32'd0);
`ifndef MOVE_CTRL_DOUBLE_JUMP_EN
    chk("air_peak_y", 32'(min_y), 32'd385);
`endif

    // Asynchronous reset mid-rise.
    jump_pulse();
    begin
      int n = 0;
      while (n < 40 && !(Move_arrow[3] && Jump_state == 2'b01)) begin step(); n++; end
    end
    chk("rise_cmd_seen", 32'(Move_arrow[3]), 32'd1);
    rst = 1'b1;
    #1;
    chk("arst_arrow", 32'(Move_arrow), 32'd0);
    chk("arst_speed", Move_speed, 32'd0);
    chk("arst_state", 32'(Jump_state), 32'd0);
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    repeat (120) step();
    chk("arst_land_y", 32'(Coordinate[15:0]), 32'd400);

    // Random button activity with occasional repositioning.
    repeat (1500) begin
      if ($urandom_range(0, 7) == 0) btn_left  = ~btn_left;
      if ($urandom_range(0, 7) == 0) btn_right = ~btn_right;
      if ($urandom_range(0, 5) == 0) btn_jump  = ~btn_jump;
      if ($urandom_range(0, 199) == 0)
        teleport({Coordinate[31:16], 16'($urandom_range(300, 400))});
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
